// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg
//   Shared types and constants for the clock-enable generator.
//   clk_mode_t   : speed mode (CLK_LOW / CLK_FULL), mirrors mode_full_o
//   CLKGEN_*     : default channel count and divisor width
//   DIV_*_USB    : default USB divisors from a 96 MHz PLL clock
//                  (full speed 48 MHz, low speed 6 MHz)
package clk_en_gen_pkg;

    typedef enum logic {
        CLK_LOW  = 1'b0,
        CLK_FULL = 1'b1
    } clk_mode_t;

    localparam int CLKGEN_NUM_CH = 2;
    localparam int CLKGEN_DIV_W  = 8;
    localparam int DIV_FS_USB    = 2;
    localparam int DIV_LS_USB    = 16;

endpackage

// File: rtl/clk_en_div.sv
// clk_en_div
//   One enable channel: down-counter, reload, registered strobe and optional
//   divided toggle output.
//   Optional feature macro: CLKGEN_TOGGLE_EN (adds o_tgl and its flop).
// Ports
//   i_clk    in   clock
//   i_rst_n  in   asynchronous active-low reset
//   i_clr    in   synchronous clear: counter, strobe and toggle to 0
//   i_div    in   divisor, sampled only on reload; 0 behaves as 1
//   o_zero   out  counter is 0 (reload happens on the next edge)
//   o_ce     out  one-cycle enable strobe, registered
//   o_tgl    out  toggles on every strobe (CLKGEN_TOGGLE_EN only)
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_zero,
    output logic             o_ce
`ifdef CLKGEN_TOGGLE_EN
    ,
    output logic             o_tgl
`endif
);

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_cnt;
    logic             r_ce;
    logic [DIV_W-1:0] w_reload;

    // A divisor of 0 reloads like a divisor of 1, so the count never wraps.
    assign w_reload = (i_div == '0) ? '0 : (i_div - ONE);
    assign o_zero   = (r_cnt == '0);
    assign o_ce     = r_ce;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_ce  <= 1'b0;
        end else if (o_zero) begin
            r_cnt <= w_reload;
            r_ce  <= 1'b1;
        end else begin
            r_cnt <= r_cnt - ONE;
            r_ce  <= 1'b0;
        end
    end

`ifdef CLKGEN_TOGGLE_EN
    logic r_tgl;

    assign o_tgl = r_tgl;

    // Flips together with the registered strobe: 50% duty, period 2*div.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tgl <= 1'b0;
        end else if (i_clr) begin
            r_tgl <= 1'b0;
        end else if (o_zero) begin
            r_tgl <= ~r_tgl;
        end
    end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen
//   Parametrised clock-enable generator in the single PLL clock domain.
//   NUM_CH channels each produce a one-cycle strobe from a runtime divisor;
//   a req/ack handshake switches all channels between the low- and full-speed
//   divisor sets, aligned to a channel-0 boundary.
//   Optional feature macro: CLKGEN_TOGGLE_EN (adds tgl_o).
// Ports
//   clk_i        in   clock for all logic
//   rst_ni       in   asynchronous active-low reset
//   div_fs_i     in   per-channel full-speed divisors, ch0 in LSBs
//   div_ls_i     in   per-channel low-speed divisors, ch0 in LSBs
//   mode_req_i   in   speed-change request level, held until ack
//   mode_full_i  in   requested mode (1 = full, 0 = low)
//   mode_ack_o   out  one-cycle pulse: request done
//   mode_full_o  out  current mode
//   busy_o       out  switch in progress (state != RUN)
//   ce_o         out  per-channel enable strobes, registered
//   ce_sync_o    out  all ce_o bits high in the same cycle
//   tgl_o        out  divided toggle outputs (CLKGEN_TOGGLE_EN only)
//
// Handshake: the requester raises mode_req_i with mode_full_i valid and holds
// both until mode_ack_o pulses. The ack cycle itself never starts a request;
// mode_req_i still high in the cycle after the ack is a new request. Once a
// switch has left RUN it always completes and acks, whatever mode_req_i and
// mode_full_i do.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter bit FULL_AT_RST = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH*DIV_W-1:0] div_fs_i,
    input  logic [NUM_CH*DIV_W-1:0] div_ls_i,
    input  logic                    mode_req_i,
    input  logic                    mode_full_i,
    output logic                    mode_ack_o,
    output logic                    mode_full_o,
    output logic                    busy_o,
    output logic [NUM_CH-1:0]       ce_o,
    output logic                    ce_sync_o
`ifdef CLKGEN_TOGGLE_EN
    ,
    output logic [NUM_CH-1:0]       tgl_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ALIGN = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam clk_mode_t MODE_RST = FULL_AT_RST ? CLK_FULL : CLK_LOW;

    state_t          r_state, w_state_nxt;
    clk_mode_t       r_mode, w_mode_nxt;
    clk_mode_t       r_target, w_target_nxt;
    logic            r_ack, w_ack_nxt;
    logic            w_clr;
    logic [NUM_CH-1:0] w_zero;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_RUN;
            r_mode   <= MODE_RST;
            r_target <= MODE_RST;
            r_ack    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_target <= w_target_nxt;
            r_ack    <= w_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_target_nxt = r_target;
        w_ack_nxt    = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (mode_req_i && !r_ack) begin
                    if (mode_full_i == (r_mode == CLK_FULL)) begin
                        w_ack_nxt = 1'b1;
                    end else begin
                        w_target_nxt = clk_mode_t'(mode_full_i);
                        w_state_nxt  = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                // At the ch0 boundary the would-be strobe is dropped and all
                // counters are zeroed, so every channel reloads from the new
                // divisor set on the next edge and strobes together.
                if (w_zero[0]) begin
                    w_mode_nxt  = r_target;
                    w_clr       = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_ack_nxt   = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] w_div;

        assign w_div = (r_mode == CLK_FULL) ? div_fs_i[c*DIV_W +: DIV_W]
                                            : div_ls_i[c*DIV_W +: DIV_W];

        clk_en_div #(
            .DIV_W(DIV_W)
        ) u_div (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_clr   (w_clr),
            .i_div   (w_div),
            .o_zero  (w_zero[c]),
            .o_ce    (ce_o[c])
`ifdef CLKGEN_TOGGLE_EN
            ,
            .o_tgl   (tgl_o[c])
`endif
        );
    end

    assign ce_sync_o   = &ce_o;
    assign mode_ack_o  = r_ack;
    assign mode_full_o = (r_mode == CLK_FULL);
    assign busy_o      = (r_state != ST_RUN);

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] div_fs_i;
  logic [15:0] div_ls_i;
  logic        mode_req_i;
  logic        mode_full_i;
  logic        mode_ack_o;
  logic        mode_full_o;
  logic        busy_o;
  logic [1:0]  ce_o;
  logic        ce_sync_o;
`ifdef CLKGEN_TOGGLE_EN
  logic [1:0]  tgl_o;
`endif

  int checks = 0;
  int errors = 0;

  clk_en_gen #(
    .NUM_CH(2),
    .DIV_W(8),
    .FULL_AT_RST(1'b1)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .div_fs_i    (div_fs_i),
    .div_ls_i    (div_ls_i),
    .mode_req_i  (mode_req_i),
    .mode_full_i (mode_full_i),
    .mode_ack_o  (mode_ack_o),
    .mode_full_o (mode_full_o),
    .busy_o      (busy_o),
    .ce_o        (ce_o),
    .ce_sync_o   (ce_sync_o)
`ifdef CLKGEN_TOGGLE_EN
    ,
    .tgl_o       (tgl_o)
`endif
  );

  // clock / reset block
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // driver tasks: advance one cycle, land 2 time units after the edge
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_ce"}, 32'(ce_o), 32'd0);
    chk({tag, "_sync"}, 32'(ce_sync_o), 32'd0);
    chk({tag, "_ack"}, 32'(mode_ack_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_mode"}, 32'(mode_full_o), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_ce;
    rst_ni      = 1'b0;
    mode_req_i  = 1'b0;
    mode_full_i = 1'b1;
    div_fs_i    = {8'd4, 8'd2};
    div_ls_i    = {8'd16, 8'd8};
    tick();
    tick();
    chk_idle_reset("rst");

    // T1: full speed, ch0 div 2, ch1 div 4
    rst_ni = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      exp_ce = {(n % 4) == 1, (n % 2) == 1};
      chk($sformatf("t1_ce_c%0d", n), 32'(ce_o), 32'(exp_ce));
      chk($sformatf("t1_sync_c%0d", n), 32'(ce_sync_o), 32'(&exp_ce));
    end

    // T2: full -> low; ch0 boundary at cycle 10, clear at 11, ack + sync at 12.
    // Request dropped and mode_full_i flipped during ALIGN must be ignored.
    mode_req_i  = 1'b1;
    mode_full_i = 1'b0;
    tick();  // cycle 10
    chk("t2_busy_c10", 32'(busy_o), 32'd1);
    chk("t2_ce_c10", 32'(ce_o), 32'd0);
    chk("t2_mode_c10", 32'(mode_full_o), 32'd1);
    mode_req_i  = 1'b0;
    mode_full_i = 1'b1;
    tick();  // cycle 11
    chk("t2_busy_c11", 32'(busy_o), 32'd1);
    chk("t2_mode_c11", 32'(mode_full_o), 32'd0);
    chk("t2_ce_supp_c11", 32'(ce_o), 32'd0);
    chk("t2_ack_c11", 32'(mode_ack_o), 32'd0);
    tick();  // cycle 12
    chk("t2_ack_c12", 32'(mode_ack_o), 32'd1);
    chk("t2_sync_c12", 32'(ce_sync_o), 32'd1);
    chk("t2_busy_c12", 32'(busy_o), 32'd0);
    for (int n = 13; n <= 28; n++) begin
      tick();
      exp_ce = {((n - 12) % 16) == 0, ((n - 12) % 8) == 0};
      chk($sformatf("t2_ce_c%0d", n), 32'(ce_o), 32'(exp_ce));
      chk($sformatf("t2_ack_c%0d", n), 32'(mode_ack_o), 32'd0);
    end

    // T3: same-mode request acks next cycle; req held through the ack cycle
    // and one more cycle forms a second request.
    mode_req_i  = 1'b1;
    mode_full_i = 1'b0;
    for (int n = 29; n <= 36; n++) begin
      tick();
      chk($sformatf("t3_ack_c%0d", n), 32'(mode_ack_o), 32'((n == 29) || (n == 31)));
      chk($sformatf("t3_busy_c%0d", n), 32'(busy_o), 32'd0);
      exp_ce = {((n - 12) % 16) == 0, ((n - 12) % 8) == 0};
      chk($sformatf("t3_ce_c%0d", n), 32'(ce_o), 32'(exp_ce));
      if (n == 31) mode_req_i = 1'b0;
    end

    // T5: reset while in ALIGN: outputs back to reset values immediately, no ack
    mode_req_i  = 1'b1;
    mode_full_i = 1'b1;
    tick();  // cycle 37
    chk("t5_busy_c37", 32'(busy_o), 32'd1);
    rst_ni     = 1'b0;
    mode_req_i = 1'b0;
    #1;
    chk_idle_reset("t5_async");
    tick();
    tick();
    chk_idle_reset("t5_hold");

    // T4: ch0 div 4 -> 3 mid-period, then 0; ch1 div 2.
    div_fs_i = {8'd2, 8'd4};
    rst_ni   = 1'b1;
    tick();  // cycle 1
    chk("t5_ce_c1", 32'(ce_o), 32'd3);
    chk("t5_mode_c1", 32'(mode_full_o), 32'd1);
    chk("t5_ack_c1", 32'(mode_ack_o), 32'd0);
    tick();  // cycle 2
    chk("t4_ce0_c2", 32'(ce_o[0]), 32'd0);
    div_fs_i[7:0] = 8'd3;
    for (int n = 3; n <= 11; n++) begin
      tick();
      chk($sformatf("t4_ce0_c%0d", n), 32'(ce_o[0]), 32'((n == 5) || (n == 8) || (n == 11)));
    end
    div_fs_i[7:0] = 8'd0;
    for (int n = 12; n <= 17; n++) begin
      tick();
      chk($sformatf("t4_div0_c%0d", n), 32'(ce_o[0]), 32'(n >= 14));
    end

`ifdef CLKGEN_TOGGLE_EN
    // T6: ch0 div 3 -> toggle period 6; forced 0 at the ALIGN->LOAD edge
    rst_ni   = 1'b0;
    div_fs_i = {8'd2, 8'd3};
    div_ls_i = {8'd8, 8'd3};
    tick();
    chk("t6_tgl_rst", 32'(tgl_o), 32'd0);
    rst_ni = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      chk($sformatf("t6_tgl0_c%0d", n), 32'(tgl_o[0]), 32'((((n - 1) / 3) % 2) == 0));
    end
    mode_req_i  = 1'b1;
    mode_full_i = 1'b0;
    tick();  // cycle 8
    tick();  // cycle 9
    chk("t6_tgl0_c9", 32'(tgl_o[0]), 32'd1);
    tick();  // cycle 10: LOAD
    chk("t6_tgl_load", 32'(tgl_o), 32'd0);
    chk("t6_busy_load", 32'(busy_o), 32'd1);
    tick();  // cycle 11
    chk("t6_ack_c11", 32'(mode_ack_o), 32'd1);
    chk("t6_tgl_c11", 32'(tgl_o), 32'd3);
    mode_req_i = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
